mac_tx_arbiter: RTL and testbench

- N-channel AXI-Stream transmit arbiter that merges several frame sources into the single Tx AXIS port of the mac/mac_pcs.
- Arbitration is round-robin and frame-atomic: a granted channel keeps the grant until its tlast beat is accepted.
- Output is a registered pipeline stage with 1-cycle latency and no throughput loss inside a frame.
- Runs entirely in the transceiver Tx clock domain, so no CDC is needed.

---
 rtl/mac_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arbiter.sv
// Frame-atomic round-robin AXI-Stream Tx arbiter feeding one registered output stage.
// Optional build macro MAC_TX_ARB_TIMEOUT_EN adds a mid-frame stall timeout with abort-beat injection.
//
// state | meaning
// IDLE  | no grant held; next requester after last_grant wins (one bubble cycle)
// BUSY  | forwarding beats of the granted channel until its tlast beat is accepted
module mac_tx_arbiter #(
   parameter int  DATA_WIDTH     = 32,
   parameter int  N_CHANNELS     = 4,
   parameter int  TIMEOUT_CYCLES = 64,
   localparam int DATA_NBYTES    = DATA_WIDTH / 8,
   localparam int ID_WIDTH       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
   input  logic                              tx_clk,
   input  logic                              tx_reset,
   input  logic [N_CHANNELS*DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [N_CHANNELS*DATA_NBYTES-1:0] s_axis_tkeep,
   input  logic [N_CHANNELS-1:0]             s_axis_tvalid,
   input  logic [N_CHANNELS-1:0]             s_axis_tlast,
   output logic [N_CHANNELS-1:0]             s_axis_tready,
   output logic [DATA_WIDTH-1:0]             m_axis_tdata,
   output logic [DATA_NBYTES-1:0]            m_axis_tkeep,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic [ID_WIDTH-1:0]               m_axis_tid,
   output logic                              m_axis_tuser
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
      $error("mac_tx_arbiter: DATA_WIDTH must be a multiple of 8");
   end
   if (N_CHANNELS < 1 || N_CHANNELS > 16) begin : g_chk_nc
      $error("mac_tx_arbiter: N_CHANNELS out of range");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_chk_to
      $error("mac_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

   state_t                  state_q, state_d;
   logic [ID_WIDTH-1:0]     grant_q, grant_d;
   logic [ID_WIDTH-1:0]     last_grant_q, last_grant_d;
   logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
   logic [DATA_NBYTES-1:0]  m_tkeep_q, m_tkeep_d;
   logic                    m_tvalid_q, m_tvalid_d;
   logic                    m_tlast_q, m_tlast_d;
   logic [ID_WIDTH-1:0]     m_tid_q, m_tid_d;

   logic [N_CHANNELS-1:0]   req;
   logic [2*N_CHANNELS-1:0] req2;
   logic [ID_WIDTH:0]       shamt;
   logic [N_CHANNELS-1:0]   rot;
   logic                    win_found;
   logic [ID_WIDTH-1:0]     win_id;
   int                      arb_off;
   int                      arb_sum;

   logic                    sel_valid;
   logic                    sel_last;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic [DATA_NBYTES-1:0]  sel_keep;
   logic                    out_free;
   logic [N_CHANNELS-1:0]   s_ready;

`ifdef MAC_TX_ARB_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [STALL_W-1:0]      stall_q, stall_d;
   logic [N_CHANNELS-1:0]   drain_q, drain_d;
   logic                    m_tuser_q, m_tuser_d;

   // A channel whose aborted frame is still being flushed must not win a new grant.
   assign req = s_axis_tvalid & ~drain_q;
`else
   assign req = s_axis_tvalid;
`endif

   // Rotate the request vector so bit 0 is the channel right after last_grant.
   always_comb begin
      req2      = {req, req};
      shamt     = {1'b0, last_grant_q} + {{ID_WIDTH{1'b0}}, 1'b1};
      rot       = N_CHANNELS'(req2 >> shamt);
      win_found = 1'b0;
      arb_off   = 0;
      for (int c = 0; c < N_CHANNELS; c++) begin
         if (!win_found && rot[c]) begin
            win_found = 1'b1;
            arb_off   = c;
         end
      end
      arb_sum = int'(last_grant_q) + 1 + arb_off;
      if (arb_sum >= N_CHANNELS) begin
         arb_sum = arb_sum - N_CHANNELS;
      end
      win_id = ID_WIDTH'(arb_sum);
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      for (int c = 0; c < N_CHANNELS; c++) begin
         if (grant_q == ID_WIDTH'(c)) begin
            sel_valid = s_axis_tvalid[c];
            sel_last  = s_axis_tlast[c];
            sel_data  = s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
            sel_keep  = s_axis_tkeep[c*DATA_NBYTES +: DATA_NBYTES];
         end
      end
   end

   assign out_free = !m_tvalid_q || m_axis_tready;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      m_tdata_d    = m_tdata_q;
      m_tkeep_d    = m_tkeep_q;
      m_tlast_d    = m_tlast_q;
      m_tid_d      = m_tid_q;
      m_tvalid_d   = m_tvalid_q;
      s_ready      = '0;
`ifdef MAC_TX_ARB_TIMEOUT_EN
      stall_d      = stall_q;
      drain_d      = drain_q;
      m_tuser_d    = m_tuser_q;
`endif

      if (m_axis_tready) begin
         m_tvalid_d = 1'b0;
      end

`ifdef MAC_TX_ARB_TIMEOUT_EN
      // Flushed beats are swallowed here and never reach the output register.
      for (int c = 0; c < N_CHANNELS; c++) begin
         if (drain_q[c]) begin
            s_ready[c] = 1'b1;
            if (s_axis_tvalid[c] && s_axis_tlast[c]) begin
               drain_d[c] = 1'b0;
            end
         end
      end
`endif

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               grant_d      = win_id;
               last_grant_d = win_id;
               state_d      = S_BUSY;
            end
         end
         S_BUSY: begin
            for (int c = 0; c < N_CHANNELS; c++) begin
               if (grant_q == ID_WIDTH'(c)) begin
                  s_ready[c] = out_free;
               end
            end
            if (sel_valid && out_free) begin
               m_tdata_d  = sel_data;
               m_tkeep_d  = sel_keep;
               m_tlast_d  = sel_last;
               m_tid_d    = grant_q;
               m_tvalid_d = 1'b1;
`ifdef MAC_TX_ARB_TIMEOUT_EN
               m_tuser_d  = 1'b0;
               stall_d    = '0;
`endif
               if (sel_last) begin
                  state_d = S_IDLE;
               end
            end
`ifdef MAC_TX_ARB_TIMEOUT_EN
            else if (stall_q == STALL_W'(TIMEOUT_CYCLES)) begin
               // Close the frame downstream with an abort beat, then flush the rest upstream.
               if (out_free) begin
                  m_tdata_d  = '0;
                  m_tkeep_d  = '0;
                  m_tlast_d  = 1'b1;
                  m_tid_d    = grant_q;
                  m_tuser_d  = 1'b1;
                  m_tvalid_d = 1'b1;
                  stall_d    = '0;
                  state_d    = S_IDLE;
                  for (int c = 0; c < N_CHANNELS; c++) begin
                     if (grant_q == ID_WIDTH'(c)) begin
                        drain_d[c] = 1'b1;
                     end
                  end
               end
            end else if (!sel_valid) begin
               stall_d = stall_q + STALL_W'(1);
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge tx_clk) begin
      if (tx_reset) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_WIDTH'(N_CHANNELS - 1);
         m_tdata_q    <= '0;
         m_tkeep_q    <= '0;
         m_tlast_q    <= 1'b0;
         m_tid_q      <= '0;
         m_tvalid_q   <= 1'b0;
`ifdef MAC_TX_ARB_TIMEOUT_EN
         stall_q      <= '0;
         drain_q      <= '0;
         m_tuser_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         m_tdata_q    <= m_tdata_d;
         m_tkeep_q    <= m_tkeep_d;
         m_tlast_q    <= m_tlast_d;
         m_tid_q      <= m_tid_d;
         m_tvalid_q   <= m_tvalid_d;
`ifdef MAC_TX_ARB_TIMEOUT_EN
         stall_q      <= stall_d;
         drain_q      <= drain_d;
         m_tuser_q    <= m_tuser_d;
`endif
      end
   end

   assign s_axis_tready = s_ready;
   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tkeep  = m_tkeep_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tlast  = m_tlast_q;
   assign m_axis_tid    = m_tid_q;
`ifdef MAC_TX_ARB_TIMEOUT_EN
   assign m_axis_tuser  = m_tuser_q;
`else
   assign m_axis_tuser  = 1'b0;
`endif

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed scoreboard bench for mac_tx_arbiter (4 channels, 32-bit data, timeout of 8 when enabled).
module tb_mac_tx_arbiter;

   localparam int DW = 32;
   localparam int NC = 4;
   localparam int NB = DW / 8;
   localparam int IW = 2;
   localparam int TO = 8;

   logic                tx_clk = 1'b0;
   logic                tx_reset;
   logic [NC*DW-1:0]    s_axis_tdata;
   logic [NC*NB-1:0]    s_axis_tkeep;
   logic [NC-1:0]       s_axis_tvalid;
   logic [NC-1:0]       s_axis_tlast;
   logic [NC-1:0]       s_axis_tready;
   logic [DW-1:0]       m_axis_tdata;
   logic [NB-1:0]       m_axis_tkeep;
   logic                m_axis_tvalid;
   logic                m_axis_tlast;
   logic                m_axis_tready;
   logic [IW-1:0]       m_axis_tid;
   logic                m_axis_tuser;

   mac_tx_arbiter #(
      .DATA_WIDTH     (DW),
      .N_CHANNELS     (NC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .tx_clk        (tx_clk),
      .tx_reset      (tx_reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .m_axis_tid    (m_axis_tid),
      .m_axis_tuser  (m_axis_tuser)
   );

   always #5 tx_clk = ~tx_clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [NB-1:0] keep;
      logic          last;
   } beat_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [NB-1:0] keep;
      logic          last;
      logic [IW-1:0] id;
      logic          user;
   } exp_t;

   beat_t         src_q [NC][$];
   exp_t          exp_q [$];
   logic [NC-1:0] en;
   bit            chk_out;
   int            tests_run    = 0;
   int            tests_failed = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk_exp(input logic [DW-1:0] d, input logic [NB-1:0] k,
                                   input logic l, input logic [IW-1:0] id, input logic u);
      exp_t e;
      e.data = d;
      e.keep = k;
      e.last = l;
      e.id   = id;
      e.user = u;
      return e;
   endfunction

   task automatic add_frame(input int c, input int n, input logic [DW-1:0] base,
                            input logic [NB-1:0] lastkeep, input bit push_exp);
      for (int i = 0; i < n; i++) begin
         beat_t b;
         b.data = base + DW'(i);
         b.keep = (i == n - 1) ? lastkeep : {NB{1'b1}};
         b.last = (i == n - 1);
         src_q[c].push_back(b);
         if (push_exp) exp_q.push_back(mk_exp(b.data, b.keep, b.last, IW'(c), 1'b0));
      end
   endtask

   task automatic drive();
      for (int c = 0; c < NC; c++) begin
         if (en[c] && src_q[c].size() > 0) begin
            s_axis_tvalid[c]          = 1'b1;
            s_axis_tdata[c*DW +: DW]  = src_q[c][0].data;
            s_axis_tkeep[c*NB +: NB]  = src_q[c][0].keep;
            s_axis_tlast[c]           = src_q[c][0].last;
         end else begin
            s_axis_tvalid[c]          = 1'b0;
            s_axis_tdata[c*DW +: DW]  = '0;
            s_axis_tkeep[c*NB +: NB]  = '0;
            s_axis_tlast[c]           = 1'b0;
         end
      end
   endtask

   // Called just after a falling edge: scores the output handshake, advances one cycle.
   task automatic tick();
      logic [NC-1:0] acc;
      exp_t          o;
      exp_t          e;
      #1;
      acc = s_axis_tvalid & s_axis_tready;
      if (chk_out && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
         o = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tuser};
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
         check("out_beat", 64'(o), 64'(e));
      end
      @(posedge tx_clk);
      #1;
      for (int c = 0; c < NC; c++) begin
         if (acc[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      end
      drive();
      @(negedge tx_clk);
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int c = 0; c < NC; c++) begin
         if (en[c] && src_q[c].size() > 0) p = 1'b1;
      end
      return p;
   endfunction

   task automatic run_until_done(input int max_cycles);
      int n = 0;
      while ((exp_q.size() > 0 || pending()) && n < max_cycles) begin
         tick();
         n++;
      end
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("sources_drained", 64'(pending()), 64'd0);
   endtask

   task automatic wait_out_valid(input int max_cycles);
      int n = 0;
      while (m_axis_tvalid !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      check("wait_out_valid", 64'(m_axis_tvalid), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tx_reset      = 1'b1;
      m_axis_tready = 1'b1;
      en            = '1;
      chk_out       = 1'b0;
      drive();
      tick();
      tick();
      tx_reset = 1'b0;
      chk_out  = 1'b1;

      // reset state
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
      check("rst_m_tkeep",  64'(m_axis_tkeep),  64'd0);
      check("rst_m_tlast",  64'(m_axis_tlast),  64'd0);
      check("rst_m_tid",    64'(m_axis_tid),    64'd0);
      check("rst_m_tuser",  64'(m_axis_tuser),  64'd0);
      check("rst_s_tready", 64'(s_axis_tready), 64'd0);

      // round robin, all channels valid, 2-beat frames: order 0,1,2,3,0,1,2,3
      for (int f = 0; f < 2; f++) begin
         for (int c = 0; c < NC; c++) begin
            add_frame(c, 2, 32'h1000 + DW'(c * 16) + DW'(f * 4), 4'hF, 1'b1);
         end
      end
      drive();
      run_until_done(60);

      // channel 2 alone, 4 beats, last tkeep 0x3: bubble + register latency
      add_frame(2, 4, 32'hA0, 4'h3, 1'b1);
      drive();
      check("lat_first_cycle", 64'(m_axis_tvalid), 64'd0);
      tick();
      check("lat_bubble", 64'(m_axis_tvalid), 64'd0);
      tick();
      check("lat_valid", 64'(m_axis_tvalid), 64'd1);
      check("lat_data", 64'(m_axis_tdata), 64'hA0);
      for (int i = 1; i < 4; i++) begin
         tick();
         check("consec_valid", 64'(m_axis_tvalid), 64'd1);
         check("consec_data", 64'(m_axis_tdata), 64'hA0 + 64'(i));
      end
      run_until_done(10);

      // channel 1 mid-frame with output backpressure 1,0,0,1
      add_frame(1, 6, 32'hB0, 4'hF, 1'b1);
      drive();
      wait_out_valid(10);
      check("bp_first_beat", 64'(m_axis_tdata), 64'hB0);
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
      #1;
      check("bp_sready_low", 64'(s_axis_tready[1]), 64'd0);
      check("bp_hold_data0", 64'(m_axis_tdata), 64'hB1);
      tick();
      check("bp_hold_valid1", 64'(m_axis_tvalid), 64'd1);
      check("bp_hold_data1", 64'(m_axis_tdata), 64'hB1);
      check("bp_sready_low1", 64'(s_axis_tready[1]), 64'd0);
      tick();
      check("bp_hold_data2", 64'(m_axis_tdata), 64'hB1);
      m_axis_tready = 1'b1;
      #1;
      check("bp_sready_high", 64'(s_axis_tready[1]), 64'd1);
      run_until_done(20);

      // reset pulse during beat 3 of an 8-beat frame on channel 2
      chk_out = 1'b0;
      add_frame(2, 8, 32'hD0, 4'hF, 1'b0);
      drive();
      wait_out_valid(10);
      tick();
      tick();
      check("pre_rst_beat3", 64'(m_axis_tdata), 64'hD2);
      tx_reset = 1'b1;
      tick();
      check("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("post_rst_sready", 64'(s_axis_tready), 64'd0);
      tx_reset = 1'b0;
      src_q[2].delete();
      drive();
      chk_out = 1'b1;
      add_frame(0, 2, 32'hE0, 4'hF, 1'b1);
      add_frame(3, 2, 32'hF0, 4'hF, 1'b1);
      drive();
      run_until_done(20);

`ifdef MAC_TX_ARB_TIMEOUT_EN
      // channel 0 stalls after 2 beats; abort beat injected, rest flushed, channel 1 follows
      add_frame(0, 4, 32'hC0, 4'hF, 1'b0);
      exp_q.push_back(mk_exp(32'hC0, 4'hF, 1'b0, 2'd0, 1'b0));
      exp_q.push_back(mk_exp(32'hC1, 4'hF, 1'b0, 2'd0, 1'b0));
      exp_q.push_back(mk_exp(32'h0,  4'h0, 1'b1, 2'd0, 1'b1));
      add_frame(1, 2, 32'hC8, 4'h3, 1'b1);
      drive();
      n = 0;
      while (src_q[0].size() > 2 && n < 20) begin
         tick();
         n++;
      end
      check("stall_point", 64'(src_q[0].size()), 64'd2);
      en[0] = 1'b0;
      drive();
      for (int i = 0; i < 20; i++) tick();
      en[0] = 1'b1;
      drive();
      run_until_done(40);
      tick();
      check("drain_cleared_sready", 64'(s_axis_tready[0]), 64'd0);
`else
      // channel 0 stalls after 2 beats for 100 cycles; frame resumes intact, no abort
      add_frame(0, 4, 32'hC0, 4'hF, 1'b1);
      drive();
      n = 0;
      while (src_q[0].size() > 2 && n < 20) begin
         tick();
         n++;
      end
      check("stall_point", 64'(src_q[0].size()), 64'd2);
      en[0] = 1'b0;
      drive();
      for (int i = 0; i < 100; i++) begin
         tick();
         check("stall_tuser", 64'(m_axis_tuser), 64'd0);
      end
      check("stall_sready_waiting", 64'(s_axis_tready[0]), 64'd1);
      check("stall_no_output", 64'(m_axis_tvalid), 64'd0);
      en[0] = 1'b1;
      drive();
      run_until_done(20);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
